// File: rtl/bf2_sdf_i_if.sv
// Sample stream bundle for one radix-2 SDF butterfly stage.
//
// Handshake: valid-only streaming with no back-pressure. A sample is
// transferred on every rising clock edge where ien=1; iaddr/idata are
// meaningful only then. On the output side oaddr/odata are meaningful only
// on cycles where oen=1. osync_err is a one-cycle pulse that stands on its
// own and is never accompanied by oen. There is no ready signal, so the
// consumer must accept every oen cycle.
interface bf2_sdf_i_if #(
  parameter int ADDR_W = 10,
  parameter int DW     = 16
);
  logic              ien;
  logic [ADDR_W-1:0] iaddr;
  logic [2*DW-1:0]   idata;
  logic              oen;
  logic [ADDR_W-1:0] oaddr;
  logic [2*DW-1:0]   odata;
  logic              osync_err;

  // Upstream producer and downstream consumer side.
  modport master (
    output ien, iaddr, idata,
    input  oen, oaddr, odata, osync_err
  );

  // Butterfly stage side.
  modport slave (
    input  ien, iaddr, idata,
    output oen, oaddr, odata, osync_err
  );
endinterface

// File: rtl/bf2_sdf_i.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Pairs samples N = 2^(FFT_STG-1) apart through an N-deep circular delay
// line and emits (a+b)>>>1 followed later by (a-b)>>>1. Stream framing is
// taken from the sample address: the stage locks on an address whose low
// FFT_STG bits are zero, primes the delay line with N samples, and drops
// lock whenever the address sequence is not contiguous.
module bf2_sdf_i #(
  parameter int FFT_STG = 7,
  parameter int ADDR_W  = 10,
  parameter int DW      = 16
) (
  input  logic       iclk,
  input  logic       irst,
  bf2_sdf_i_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int N     = 1 << (FFT_STG - 1);
  localparam int PTR_W = (FFT_STG > 1) ? FFT_STG - 1 : 1;
  localparam int CNT_W = FFT_STG;
  localparam int EW    = ADDR_W + 2 * DW;

  // UNLOCK: waiting for a block-aligned address.
  // PRIME : locked, delay line still filling (oen held low).
  // RUN   : locked and producing outputs.
  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_PRIME  = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  prime_cnt;
  logic [CNT_W-1:0]  prime_cnt_nxt;
  logic [ADDR_W-1:0] prev_addr;
  logic [PTR_W-1:0]  ptr;
  logic [EW-1:0]     mem [N];

  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DW-1:0]     head_re;
  logic [DW-1:0]     head_im;
  logic [DW-1:0]     x_re;
  logic [DW-1:0]     x_im;
  logic [DW:0]       sum_re;
  logic [DW:0]       sum_im;
  logic [DW:0]       dif_re;
  logic [DW:0]       dif_im;

  logic              low_zero;
  logic              addr_ok;
  logic              half_b;
  logic              push;
  logic              out_vld;
  logic              sync_err;
  logic              relock;
  logic [ADDR_W-1:0] push_addr;
  logic [2*DW-1:0]   push_data;
  logic [ADDR_W-1:0] out_addr;
  logic [2*DW-1:0]   out_data;

  assign dbg_state = state;

  // Framing decode of the incoming address.
  assign low_zero = (bus.iaddr[FFT_STG-1:0] == '0);
  assign addr_ok  = (bus.iaddr == prev_addr + ADDR_W'(1));
  assign half_b   = bus.iaddr[FFT_STG-1];

  // Delay-line head is the oldest entry, i.e. the slot about to be reused.
  assign head      = mem[ptr];
  assign head_addr = head[EW-1:2*DW];
  assign head_re   = head[2*DW-1:DW];
  assign head_im   = head[DW-1:0];
  assign x_re      = bus.idata[2*DW-1:DW];
  assign x_im      = bus.idata[DW-1:0];

  // One guard bit keeps the sum/difference exact before the halving shift.
  assign sum_re = {head_re[DW-1], head_re} + {x_re[DW-1], x_re};
  assign sum_im = {head_im[DW-1], head_im} + {x_im[DW-1], x_im};
  assign dif_re = {head_re[DW-1], head_re} - {x_re[DW-1], x_re};
  assign dif_im = {head_im[DW-1], head_im} - {x_im[DW-1], x_im};

  // State register: only enabled samples advance the FSM.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= ST_UNLOCK;
      prime_cnt <= '0;
    end else if (bus.ien) begin
      state     <= state_nxt;
      prime_cnt <= prime_cnt_nxt;
    end
  end

  // Next-state logic: lock, priming count and loss of lock.
  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    if (relock) begin
      prime_cnt_nxt = CNT_W'(1);
      state_nxt     = (N == 1) ? ST_RUN : ST_PRIME;
    end else if (sync_err) begin
      prime_cnt_nxt = '0;
      state_nxt     = ST_UNLOCK;
    end else if (push && (state == ST_PRIME)) begin
      prime_cnt_nxt = prime_cnt + CNT_W'(1);
      if (prime_cnt_nxt == CNT_W'(N)) begin
        state_nxt = ST_RUN;
      end
    end
  end

  // Output decode: what the current enabled sample does.
  always_comb begin
    push     = 1'b0;
    out_vld  = 1'b0;
    sync_err = 1'b0;
    relock   = 1'b0;
    if (bus.ien) begin
      case (state)
        ST_UNLOCK: begin
          if (low_zero) begin
            push   = 1'b1;
            relock = 1'b1;
          end
        end
        default: begin
          if (!addr_ok) begin
            // The offending sample may itself start a new lock.
            sync_err = 1'b1;
            if (low_zero) begin
              push   = 1'b1;
              relock = 1'b1;
            end
          end else begin
            push    = 1'b1;
            out_vld = (state == ST_RUN);
          end
        end
      endcase
    end
  end

  // Butterfly datapath: first half stores, second half combines.
  always_comb begin
    push_addr = bus.iaddr;
    push_data = bus.idata;
    out_addr  = head_addr;
    out_data  = head[2*DW-1:0];
    if (half_b) begin
      push_addr            = head_addr;
      push_addr[FFT_STG-1] = 1'b1;
      push_data            = {dif_re[DW:1], dif_im[DW:1]};
      out_data             = {sum_re[DW:1], sum_im[DW:1]};
    end
  end

  // Delay-line storage; contents are don't-care until primed.
  always_ff @(posedge iclk) begin
    if (push) begin
      mem[ptr] <= {push_addr, push_data};
    end
  end

  // Circular pointer and address-continuity tracking.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ptr       <= '0;
      prev_addr <= '0;
    end else if (push) begin
      ptr       <= (ptr == PTR_W'(N - 1)) ? '0 : ptr + PTR_W'(1);
      prev_addr <= bus.iaddr;
    end
  end

  // Registered outputs; address/data hold when no sample is emitted.
  always_ff @(posedge iclk) begin
    if (irst) begin
      bus.oen       <= 1'b0;
      bus.oaddr     <= '0;
      bus.odata     <= '0;
      bus.osync_err <= 1'b0;
    end else begin
      bus.oen       <= out_vld;
      bus.osync_err <= sync_err;
      if (out_vld) begin
        bus.oaddr <= out_addr;
        bus.odata <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_bf2_sdf_i.sv
// Bench for bf2_sdf_i: two instances (FFT_STG=2 and 3) share one stimulus
// stream. A frame-level reference model predicts every output; a table of
// hand-computed vectors pins the FFT_STG=2 instance to known values.
module tb_bf2_sdf_i;
  localparam int AW = 10;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf2_sdf_i_if #(.ADDR_W(AW), .DW(DW)) bus0 ();
  bf2_sdf_i_if #(.ADDR_W(AW), .DW(DW)) bus1 ();
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  bf2_sdf_i #(.FFT_STG(2), .ADDR_W(AW), .DW(DW)) dut0 (
    .iclk(clk), .irst(rst), .bus(bus0), .dbg_state(dbg0));
  bf2_sdf_i #(.FFT_STG(3), .ADDR_W(AW), .DW(DW)) dut1 (
    .iclk(clk), .irst(rst), .bus(bus1), .dbg_state(dbg1));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+2*DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: lock flag, last address, index within the locked run,
  // and a history of the raw samples of that run.
  int                 m_n[2]   = '{2, 4};
  bit                 m_locked[2];
  logic [AW-1:0]      m_prev[2];
  int                 m_cnt[2];
  logic [AW+2*DW-1:0] m_hist[2][64];
  bit                 e_oen[2];
  bit                 e_err[2];

  function automatic int re_of(input logic [AW+2*DW-1:0] v);
    logic signed [15:0] t;
    t = v[31:16];
    return int'(t);
  endfunction

  function automatic int im_of(input logic [AW+2*DW-1:0] v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic model_step(input int s, input bit r, input bit e,
                            input logic [AW-1:0] a, input logic [31:0] d);
    int idx, p, off, n, mask, rr, ii;
    logic [AW+2*DW-1:0] x, y;
    logic [AW-1:0] nxt;
    e_oen[s] = 1'b0;
    e_err[s] = 1'b0;
    n    = m_n[s];
    mask = 2 * n - 1;
    if (r) begin
      m_locked[s] = 1'b0;
      return;
    end
    if (!e) return;
    nxt = m_prev[s] + 10'd1;
    if (m_locked[s] && (a != nxt)) begin
      e_err[s]    = 1'b1;
      m_locked[s] = 1'b0;
    end
    if (!m_locked[s]) begin
      if ((int'(a) & mask) != 0) return;
      m_locked[s] = 1'b1;
      m_cnt[s]    = 0;
    end
    idx = m_cnt[s];
    m_hist[s][idx % 64] = {a, d};
    m_prev[s] = a;
    m_cnt[s]++;
    if (idx >= n) begin
      // Output slot idx carries the butterfly result for run position idx-n.
      p   = idx - n;
      off = p % (2 * n);
      if (off < n) begin
        x  = m_hist[s][p % 64];
        y  = m_hist[s][idx % 64];
        rr = (re_of(x) + re_of(y)) >>> 1;
        ii = (im_of(x) + im_of(y)) >>> 1;
      end else begin
        x  = m_hist[s][(p - n) % 64];
        y  = m_hist[s][p % 64];
        rr = (re_of(x) - re_of(y)) >>> 1;
        ii = (im_of(x) - im_of(y)) >>> 1;
      end
      e_oen[s] = 1'b1;
      exp_q.push_back({m_hist[s][p % 64][AW+2*DW-1:2*DW], 16'(rr), 16'(ii)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit e, input logic [AW-1:0] a, input logic [31:0] d);
    logic a_oen, a_err;
    logic [AW-1:0] a_addr;
    logic [31:0] a_data;
    logic [AW+2*DW-1:0] ev;
    @(negedge clk);
    rst = r;
    bus0.ien = e; bus0.iaddr = a; bus0.idata = d;
    bus1.ien = e; bus1.iaddr = a; bus1.idata = d;
    @(posedge clk);
    for (int s = 0; s < 2; s++) model_step(s, r, e, a, d);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        a_oen = bus0.oen; a_err = bus0.osync_err; a_addr = bus0.oaddr; a_data = bus0.odata;
      end else begin
        a_oen = bus1.oen; a_err = bus1.osync_err; a_addr = bus1.oaddr; a_data = bus1.odata;
      end
      chk($sformatf("d%0d_oen", s), 64'(a_oen), 64'(e_oen[s]));
      chk($sformatf("d%0d_sync_err", s), 64'(a_err), 64'(e_err[s]));
      if (r) begin
        chk($sformatf("d%0d_rst_oaddr", s), 64'(a_addr), 64'd0);
        chk($sformatf("d%0d_rst_odata", s), 64'(a_data), 64'd0);
      end
      if (e_oen[s]) begin
        ev = exp_q.pop_front();
        chk($sformatf("d%0d_oaddr", s), 64'(a_addr), 64'(ev[AW+2*DW-1:2*DW]));
        chk($sformatf("d%0d_odata", s), 64'(a_data), 64'(ev[2*DW-1:0]));
      end
    end
  endtask

  // ---------------- vector table (FFT_STG=2 instance) ----------------
  typedef struct {
    bit                 r;
    bit                 e;
    logic [AW-1:0]      a;
    logic signed [15:0] re;
    logic signed [15:0] im;
    bit                 eoen;
    bit                 eerr;
    logic [AW-1:0]      eaddr;
    logic signed [15:0] ere;
    logic signed [15:0] eim;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit e, input int a, input int re, input int im,
                              input bit eoen, input bit eerr, input int eaddr,
                              input int ere, input int eim);
    vec_t v;
    v.r = r; v.e = e; v.a = AW'(a); v.re = 16'(re); v.im = 16'(im);
    v.eoen = eoen; v.eerr = eerr; v.eaddr = AW'(eaddr); v.ere = 16'(ere); v.eim = 16'(eim);
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] rnd_comp();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  int t1_oen[8] = '{0, 0, 1, 1, 1, 1, 1, 1};
  int t1_adr[8] = '{0, 0, 0, 1, 2, 3, 4, 5};
  int t1_re[8]  = '{0, 0, 2, 3, -1, -1, 6, 7};

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] addr;
    int n_en;
    bus0.ien = 1'b0; bus0.iaddr = '0; bus0.idata = '0;
    bus1.ien = 1'b0; bus1.iaddr = '0; bus1.idata = '0;

    // Basic stream, floor rounding and extreme values.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, i, i + 1, 0, t1_oen[i] != 0, 0, t1_adr[i], t1_re[i], 0);
    add(0, 1,  8,      1, 0, 1, 0,  6,     -1,  0);
    add(0, 1,  9,      0, 0, 1, 0,  7,     -1,  0);
    add(0, 1, 10,      2, 1, 1, 0,  8,      1,  0);
    add(0, 1, 11,      0, 0, 1, 0,  9,      0,  0);
    add(0, 1, 12, -32768, 0, 1, 0, 10,     -1, -1);
    add(0, 1, 13,      0, 0, 1, 0, 11,      0,  0);
    add(0, 1, 14, -32768, 0, 1, 0, 12, -32768,  0);
    add(0, 1, 15,      0, 0, 1, 0, 13,      0,  0);
    add(0, 1, 16,      0, 0, 1, 0, 14,      0,  0);
    add(0, 1, 17,      0, 0, 1, 0, 15,      0,  0);
    // Same stream with idle cycles between samples.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      add(0, 1, i, i + 1, 0, t1_oen[i] != 0, 0, t1_adr[i], t1_re[i], 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    // Lock on an aligned address, lose lock on a skip, re-lock.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  3,  9, 0, 0, 0, 0,  0, 0);
    add(0, 1,  4, 10, 0, 0, 0, 0,  0, 0);
    add(0, 1,  5, 11, 0, 0, 0, 0,  0, 0);
    add(0, 1,  7, 12, 0, 0, 1, 0,  0, 0);
    add(0, 1,  8, 13, 0, 0, 0, 0,  0, 0);
    add(0, 1,  9, 14, 0, 0, 0, 0,  0, 0);
    add(0, 1, 10, 15, 0, 1, 0, 8, 14, 0);
    add(0, 1, 11, 16, 0, 1, 0, 9, 15, 0);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].e, vecs[k].a, {vecs[k].re, vecs[k].im});
      chk("tv_oen", 64'(bus0.oen), 64'(vecs[k].eoen));
      chk("tv_sync_err", 64'(bus0.osync_err), 64'(vecs[k].eerr));
      if (vecs[k].eoen) begin
        chk("tv_oaddr", 64'(bus0.oaddr), 64'(vecs[k].eaddr));
        chk("tv_odata", 64'(bus0.odata), 64'({vecs[k].ere, vecs[k].eim}));
      end
    end

    // Reset mid-frame on the FFT_STG=3 instance, then restart at 0.
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, AW'(i), $urandom);
    step(1, 1, 6, $urandom);
    n_en = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, AW'(i), {rnd_comp(), rnd_comp()});
      n_en++;
      if (n_en <= 4) chk("rst_prime_oen", 64'(bus1.oen), 64'd0);
    end

    // Randomized traffic: idle gaps, occasional address jumps and resets,
    // starting close to the address wrap point.
    addr = 10'd1000;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, e;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) < 7);
      if (e && ($urandom_range(0, 39) == 0)) addr = AW'($urandom);
      step(r, e, addr, {rnd_comp(), rnd_comp()});
      if (e && !r) addr = addr + 10'd1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bf2_sdf_i.md
Name: bf2_sdf_I

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage of the pipelined streaming FFT.
- Sits directly upstream of the trivial -j rotation stage for the same FFT_STG and feeds it the same en/addr/data stream format.
- Pairs samples N = 2^(FFT_STG-1) apart using an internal delay line and emits sum/difference with 1-bit scaling.
- Stream control comes from the sample address bits, not a free-running counter.

Parameters:
- FFT_STG, 7, stage index; butterfly span N = 2^(FFT_STG-1); legal range 1..ADDR_W.
- ADDR_W, 10, sample address width (total FFT stages, log2 of FFT length).
- DW, 16, width of each real/imag component, signed two's complement.

Ports:
- iclk, input, 1, clock, rising edge.
- irst, input, 1, synchronous active-high reset.
- ien, input, 1, input sample valid.
- iaddr, input, ADDR_W, index of the input sample within the FFT frame.
- idata, input, 2*DW, complex sample; real in [2*DW-1:DW], imag in [DW-1:0].
- oen, output, 1, output sample valid.
- oaddr, output, ADDR_W, index of the output sample.
- odata, output, 2*DW, complex result; same packing as idata.
- osync_err, output, 1, one-cycle pulse on a detected address discontinuity.

Behaviour:
- Reset (irst=1 at a clock edge):
  - oen=0, oaddr=0, odata=0, osync_err=0.
  - lock=0, prime count=0.
  - Delay-line contents need not be cleared.
  - Reset dominates ien in the same cycle, and reset mid-frame discards everything in flight.
- Delay line:
  - N entries of {addr, data}, implemented as a circular buffer or shift register.
  - Advances only on cycles where ien=1. ien=0 freezes all state, and oen=0 on the following cycle.
- Lock/prime:
  - Unlocked samples are dropped (no write, oen=0) until a sample with iaddr[FFT_STG-1:0]==0 arrives.
  - That sample sets lock=1 and is processed normally.
  - After lock, the first N enabled samples fill the delay line with oen held 0. Valid output starts on sample N+1.
- Per enabled locked sample x with b = iaddr[FFT_STG-1]; d = delay-line head {addr_d, data_d}:
  - b=0: output d (the stored difference, passed through unchanged); push {iaddr, x}.
  - b=1: output (d + x) >>> 1; push {addr_d with bit FFT_STG-1 set to 1, (d - x) >>> 1}; output address = addr_d.
  - Arithmetic is per component at DW+1 bits, then arithmetic shift right by 1 (floor, no rounding), giving DW bits. No overflow is possible.
- Latency and ordering:
  - Registered output: oen/oaddr/odata are valid 1 clock after the accepting ien edge.
  - In enabled samples, the output stream lags the input by N. oaddr equals the iaddr of the sample N enabled samples earlier.
  - Within each 2N block: first half = sums, second half = differences, in natural order.
- Address check (while locked):
  - Expected iaddr = previous iaddr + 1 mod 2^ADDR_W.
  - On mismatch: osync_err=1 for one cycle (aligned with where the oen slot would be); oen=0 for that sample; lock=0, prime=0.
  - Re-lock then follows the normal rule, so the offending sample may itself re-lock if its low bits are 0.
- End of stream: the last N differences stay in the delay line until N further samples are pushed. There is no flush mechanism.
- Wrap-around: iaddr rolling from 2^ADDR_W-1 to 0 is continuous and is not an error.

Test Plan:
1. FFT_STG=2, DW=16, reset then real inputs 1,2,3,4 at addr 0..3 (imag 0), ien continuous, then 5,6,7,8 at addr 4..7:
   - No oen during samples 1,2.
   - Samples 3,4 -> odata real 2 @oaddr 0, real 3 @oaddr 1.
   - Samples 5,6 -> real -1 @2, real -1 @3.
   - Samples 7,8 -> real 6 @4, real 7 @5.
2. Floor rounding, FFT_STG=2: inputs (1+j0),(0),(2+j1),(0) at addr 0..3 -> sum odata = 1 + j0 (real 3>>>1=1, imag 1>>>1=0); difference later = -1 - j1 (real -1>>>1=-1, imag -1>>>1=-1).
3. Extremes, FFT_STG=2: inputs -32768 and -32768, N apart -> sum -32768 and difference 0, with no wrap.
4. Gaps: repeat test 1 with ien=0 on alternate cycles -> identical odata/oaddr sequence; oen only one cycle after each ien=1.
5. Lock and re-lock: first samples at addr 3 then 4 (FFT_STG=2) -> addr 3 dropped, lock on addr 4. Then skip an address (4,5,7) -> osync_err pulse at the sample with addr 7, oen=0, priming restarts.
6. Reset mid-frame, FFT_STG=3: after 6 samples assert irst for 1 cycle, restart at addr 0 -> oen=0 for the first 4 enabled samples after reset; outputs afterwards match a fresh run.
